mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//   Execute-stage multiply/divide unit: the consumer of the E_sel_MDU op code driven by the decoder.
//   Owns the architectural HI/LO registers and models fixed multi-cycle mult/div latency.
//   Exports busy/start so the hazard unit can stall D-stage md/mt/mf instructions (D_instr_mdu).
//   Drives the mfhi/mflo result into the E->M pipeline register.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles after start for mult/multu
//   DIV_CYCLES   10  busy cycles after start for div/divu
// PORTS
//   clk        in   1   single clock, rising edge
//   reset_n    in   1   asynchronous, active-low reset
//   E_sel_MDU  in   4   op code from decoder: mult=0, multu=1, div=2, divu=3, mfhi=4, mflo=5, mthi=6, mtlo=7, none=4'hF
//   E_valid    in   1   E-stage instruction is real (not a bubble, not flushed)
//   E_cancel   in   1   exception/eret committing this cycle; current E op must not take effect
//   E_rs       in   32  forwarded rs operand
//   E_rt       in   32  forwarded rt operand
//   start      out  1   combinational; an md op is accepted this cycle
//   busy       out  1   registered; an md op is in flight
//   E_mdu_out  out  32  combinational: HI for mfhi, LO for mflo, else 32'h0
//   hi_q       out  32  current HI (debug/trace)
//   lo_q       out  32  current LO (debug/trace)
// BEHAVIOUR
//   Reset (async, reset_n=0): HI=LO=0, busy=0, counter=0, pending result cleared. Takes effect immediately, mid-op included.
//   accept   = E_valid & ~E_cancel & ~busy
//   start    = accept & (op in {mult, multu, div, divu})
//   States: IDLE, BUSY.
//   IDLE + start -> BUSY
//     - counter loaded with MULT_CYCLES or DIV_CYCLES
//     - {hi_n, lo_n} computed from E_rs/E_rt that cycle and held in pending registers
//   BUSY: counter decrements each cycle; busy=1 while counter != 0.
//     - When counter goes 1->0: HI/LO take the pending values on that edge; busy drops to 0 after that edge.
//   Observable latency: start in cycle T -> busy=1 for cycles T+1..T+N; new HI/LO visible from cycle T+N+1.
//   Arithmetic:
//     - mult: signed 32x32 -> 64, HI=[63:32], LO=[31:0]; multu: unsigned.
//     - div: LO=quotient, HI=remainder, truncate toward zero, remainder sign follows dividend; divu: unsigned.
//     - Divide by zero: op still occupies DIV_CYCLES; HI/LO are left unchanged.
//   mthi/mtlo: on accept, HI (or LO) <= E_rs at that edge, no busy.
//   mfhi/mflo: E_mdu_out reflects HI/LO of the current cycle (pure read, no state change).
//   Boundary conditions:
//     - Any op while busy=1 is ignored (hazard unit stalls these; no queuing).
//     - E_cancel=1 blocks start and mt writes that cycle. It never aborts an op already in BUSY, because that op has already committed.
//     - E_valid=0 or op=4'hF: no state change.
//     - A new start is legal in the first cycle busy=0; back-to-back ops are separated only by the latency.
// STRUCTURE
//   Op-code constants (mdu_*) and latency defaults belong in the shared const header; add no private encodings.
//   One sub-module is natural: mdu_busy_timer (load value, load strobe, down-counter, done pulse, busy).
//   The 64-bit product and quotient/remainder datapath stays in mdu_unit.
// TESTING
//   1. mult rs=-3 (FFFFFFFD), rt=7 at T -> busy high T+1..T+5; HI=FFFFFFFF, LO=FFFFFFEB at T+6.
//   2. divu rs=100, rt=7 -> busy 10 cycles, then LO=14, HI=2; div rs=-7, rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//   3. mthi rs=DEADBEEF, then a div by zero (rt=0) -> busy 10 cycles; HI stays DEADBEEF, LO unchanged.
//   4. mult with E_cancel=1 -> start=0, busy stays 0, HI/LO unchanged.
//      mtlo with E_cancel=1 -> LO unchanged.
//   5. mult issued, then reset_n pulsed low at cycle T+3 -> busy=0, HI=LO=0 immediately; no late write after release.
//   6. mult 2x3 during busy (E_valid=1) -> ignored.
//      Then mflo in the first non-busy cycle returns the first op's LO; mfhi at T+6 returns the committed HI.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared constants for the multiply/divide unit: op codes, default latencies, FSM encoding.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MDU_MULT  = 4'h0,
    MDU_MULTU = 4'h1,
    MDU_DIV   = 4'h2,
    MDU_DIVU  = 4'h3,
    MDU_MFHI  = 4'h4,
    MDU_MFLO  = 4'h5,
    MDU_MTHI  = 4'h6,
    MDU_MTLO  = 4'h7,
    MDU_NONE  = 4'hF
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;
  localparam int          MDU_CNT_W       = 4;

  // Multi-cycle ops occupy the low four encodings.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// E-stage request/response bundle between the pipeline and the multiply/divide unit.
interface mdu_unit_if;
  logic [3:0]  E_sel_MDU;
  logic        E_valid;
  logic        E_cancel;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        start;
  logic        busy;
  logic [31:0] E_mdu_out;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport master (
    output E_sel_MDU, E_valid, E_cancel, E_rs, E_rt,
    input  start, busy, E_mdu_out, hi_q, lo_q
  );

  modport slave (
    input  E_sel_MDU, E_valid, E_cancel, E_rs, E_rt,
    output start, busy, E_mdu_out, hi_q, lo_q
  );
endinterface

// File: rtl/mdu_busy_timer.sv
// Latency down-counter: loads on strobe, counts to zero, flags the final busy cycle.
module mdu_busy_timer
  import mdu_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [MDU_CNT_W-1:0] load_val,
  output logic                 done,
  output logic                 busy
);

  logic [MDU_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // done marks the cycle whose closing edge takes the count 1 -> 0.
  assign done = (cnt == MDU_CNT_W'(1));
  assign busy = (cnt != '0);

endmodule

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit owning HI/LO with fixed mult/div latency.
//   state    | meaning
//   MDU_IDLE | no md op in flight; accepts md and mt ops
//   MDU_BUSY | result held in pending regs, committed to HI/LO on timer done
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input logic        clk,
  input logic        reset_n,
  mdu_unit_if.slave  mdu
);

  mdu_state_e           state;
  logic                 accept, start, is_div, busy, done, wr_n;
  logic [MDU_CNT_W-1:0] load_val;
  logic [63:0]          prod_s, prod_u, res_n;
  logic [31:0]          divisor, quot_s, rem_s, quot_u, rem_u;
  logic [31:0]          hi_q, lo_q, pend_hi, pend_lo;
  logic                 pend_wr;

  assign accept   = mdu.E_valid & ~mdu.E_cancel & ~busy;
  assign start    = accept & is_md_op(mdu.E_sel_MDU);
  assign is_div   = (mdu.E_sel_MDU == MDU_DIV) || (mdu.E_sel_MDU == MDU_DIVU);
  assign load_val = is_div ? MDU_CNT_W'(DIV_CYCLES) : MDU_CNT_W'(MULT_CYCLES);
  // Divide by zero still burns the full latency but leaves HI/LO alone.
  assign wr_n     = ~(is_div && (mdu.E_rt == '0));

  always_comb begin
    divisor = (mdu.E_rt == '0) ? 32'd1 : mdu.E_rt;
    prod_s  = $signed({{32{mdu.E_rs[31]}}, mdu.E_rs}) * $signed({{32{mdu.E_rt[31]}}, mdu.E_rt});
    prod_u  = {32'b0, mdu.E_rs} * {32'b0, mdu.E_rt};
    quot_s  = $signed(mdu.E_rs) / $signed(divisor);
    rem_s   = $signed(mdu.E_rs) % $signed(divisor);
    quot_u  = mdu.E_rs / divisor;
    rem_u   = mdu.E_rs % divisor;
    case (mdu.E_sel_MDU)
      MDU_MULT:  res_n = prod_s;
      MDU_MULTU: res_n = prod_u;
      MDU_DIV:   res_n = {rem_s, quot_s};
      MDU_DIVU:  res_n = {rem_u, quot_u};
      default:   res_n = '0;
    endcase
  end

  mdu_busy_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start),
    .load_val (load_val),
    .done     (done),
    .busy     (busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= MDU_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            state   <= MDU_BUSY;
            pend_hi <= res_n[63:32];
            pend_lo <= res_n[31:0];
            pend_wr <= wr_n;
          end else if (accept && (mdu.E_sel_MDU == MDU_MTHI)) begin
            hi_q <= mdu.E_rs;
          end else if (accept && (mdu.E_sel_MDU == MDU_MTLO)) begin
            lo_q <= mdu.E_rs;
          end
        end
        MDU_BUSY: begin
          if (done) begin
            state   <= MDU_IDLE;
            pend_wr <= 1'b0;
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  assign mdu.start     = start;
  assign mdu.busy      = busy;
  assign mdu.hi_q      = hi_q;
  assign mdu.lo_q      = lo_q;
  assign mdu.E_mdu_out = (mdu.E_sel_MDU == MDU_MFHI) ? hi_q :
                         (mdu.E_sel_MDU == MDU_MFLO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: vector table for ops plus hand sequences for cancel/busy/reset.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[15];

  mdu_unit_if mif ();

  mdu_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mdu     (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mif.E_sel_MDU = MDU_NONE;
    mif.E_valid   = 1'b0;
    mif.E_cancel  = 1'b0;
    mif.E_rs      = '0;
    mif.E_rt      = '0;
  endtask

  // Called 1 ns after a rising edge; presents one op for one cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic cancel, input logic exp_start, input string name);
    mif.E_sel_MDU = op;
    mif.E_rs      = rs;
    mif.E_rt      = rt;
    mif.E_valid   = 1'b1;
    mif.E_cancel  = cancel;
    #1;
    check($sformatf("%s start", name), 32'(mif.start), 32'(exp_start));
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic count_busy(input int exp_lat, input string name);
    int n;
    n = 0;
    while (mif.busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check($sformatf("%s busy cycles", name), 32'(n), 32'(exp_lat));
  endtask

  task automatic check_regs(input logic [31:0] hi, input logic [31:0] lo, input string name);
    check($sformatf("%s hi_q", name), mif.hi_q, hi);
    check($sformatf("%s lo_q", name), mif.lo_q, lo);
    mif.E_sel_MDU = MDU_MFHI; #1;
    check($sformatf("%s mfhi", name), mif.E_mdu_out, hi);
    mif.E_sel_MDU = MDU_MFLO; #1;
    check($sformatf("%s mflo", name), mif.E_mdu_out, lo);
    mif.E_sel_MDU = MDU_NONE; #1;
    check($sformatf("%s out idle", name), mif.E_mdu_out, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{MDU_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h00000000, 0};
    vecs[1]  = '{MDU_MTLO,  32'h12345678, 32'h0,        32'hDEADBEEF, 32'h12345678, 0};
    vecs[2]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[3]  = '{MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[4]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[5]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[6]  = '{MDU_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFE, 0};
    vecs[7]  = '{MDU_DIV,   32'h00000005, 32'h00000000, 32'hDEADBEEF, 32'hFFFFFFFE, 10};
    vecs[8]  = '{MDU_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[9]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[10] = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[11] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[12] = '{MDU_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10};
    vecs[13] = '{MDU_NONE,  32'hAAAA5555, 32'h00000003, 32'h00000005, 32'h19999999, 0};
    vecs[14] = '{MDU_MFHI,  32'h5555AAAA, 32'h00000004, 32'h00000005, 32'h19999999, 0};

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(mif.busy), 32'h0);
    check("reset start", 32'(mif.start), 32'h0);
    check("reset hi_q", mif.hi_q, 32'h0);
    check("reset lo_q", mif.lo_q, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, vecs[i].lat != 0, $sformatf("vec%0d", i));
      count_busy(vecs[i].lat, $sformatf("vec%0d", i));
      check_regs(vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Cancelled ops must leave HI/LO and busy untouched.
    issue(MDU_MTHI, 32'h11111111, 32'h0, 1'b0, 1'b0, "seed hi");
    issue(MDU_MTLO, 32'h22222222, 32'h0, 1'b0, 1'b0, "seed lo");
    check_regs(32'h11111111, 32'h22222222, "seed");
    @(posedge clk); #1;
    issue(MDU_MULT, 32'd3, 32'd4, 1'b1, 1'b0, "cancel mult");
    check("cancel mult busy", 32'(mif.busy), 32'h0);
    @(posedge clk); #1;
    check("cancel mult busy later", 32'(mif.busy), 32'h0);
    check_regs(32'h11111111, 32'h22222222, "cancel mult");
    issue(MDU_MTLO, 32'h00000099, 32'h0, 1'b1, 1'b0, "cancel mtlo");
    check_regs(32'h11111111, 32'h22222222, "cancel mtlo");
    @(posedge clk); #1;

    // Op presented while busy is dropped; new start legal in first idle cycle.
    issue(MDU_MULT, 32'd6, 32'd7, 1'b0, 1'b1, "first mult");
    mif.E_sel_MDU = MDU_MULT;
    mif.E_rs      = 32'd2;
    mif.E_rt      = 32'd3;
    mif.E_valid   = 1'b1;
    #1;
    check("busy mult start T+1", 32'(mif.start), 32'h0);
    @(posedge clk); #1;
    check("busy mult start T+2", 32'(mif.start), 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    count_busy(3, "first mult rest");
    check_regs(32'h0, 32'd42, "first mult");
    issue(MDU_MULT, 32'd2, 32'd3, 1'b0, 1'b1, "b2b mult");
    count_busy(5, "b2b mult");
    check_regs(32'h0, 32'd6, "b2b mult");
    @(posedge clk); #1;

    // Reset mid-op clears everything at once, and nothing lands afterwards.
    issue(MDU_MULT, 32'd5, 32'd5, 1'b0, 1'b1, "reset mult");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-reset busy", 32'(mif.busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("async reset busy", 32'(mif.busy), 32'h0);
    check("async reset hi_q", mif.hi_q, 32'h0);
    check("async reset lo_q", mif.lo_q, 32'h0);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post-reset busy", 32'(mif.busy), 32'h0);
    check_regs(32'h0, 32'h0, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
